mem_arbiter: RTL and testbench

- Sequences the single-port data RAM (1024 x 32, combinational read, write on posedge clk) and shares it between two requesters: instruction fetch (IF) and load/store unit (LS).
- Arbitrates round-robin and performs byte/halfword load alignment with sign/zero extension.
- Sub-word stores use a two-cycle read-modify-write (RMW).
- Sits between the core pipeline and the RAM instance in mem_unit.

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_arbiter_lane_align.sv | 36 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the data-RAM arbiter: access sizes,
// FSM states, grant identities and the address legality check.
package mem_arbiter_pkg;

   localparam int unsigned MEM_WORDS_DEF = 1024;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE,
      ST_RMW
   } state_e;

   typedef enum logic {
      GNT_IF,
      GNT_LS
   } grant_e;

   // True when the access is misaligned for its size, has an illegal size,
   // or indexes a word beyond the end of the RAM.
   function automatic logic addr_err(input logic [31:0] addr, input size_e size,
                                     input int unsigned words);
      logic bad;
      bad = ({2'b00, addr[31:2]} >= words);
      case (size)
         SZ_BYTE: ;
         SZ_HALF: bad = bad | addr[0];
         SZ_WORD: bad = bad | (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and
// sub-word store merge, shared by the load path and the RMW write path.
module mem_lane_align
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v  = word_i[{addr_lo_i, 3'b000} +: 8];
      half_v  = word_i[{addr_lo_i[1], 4'b0000} +: 16];
      load_o  = word_i;
      merge_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the single-port data RAM between fetch and the
// load/store unit, with load alignment and two-cycle sub-word stores.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_err,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [31:0] ls_addr,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [31:0] ls_wdata,
   output logic        ls_rsp_valid,
   output logic [31:0] ls_rsp_data,
   output logic        ls_err,
   output logic [31:0] ram_addr,
   output logic        ram_wr_sig,
   output logic [31:0] ram_wr_data,
   input  logic [31:0] ram_rd_data
);

   state_e      state_q;
   grant_e      last_grant_q;
   logic [31:0] merge_q, rmw_addr_q;
   logic [15:0] rmw_wdata_q;
   size_e       rmw_size_q;
   logic        if_rsp_valid_q, if_err_q, ls_rsp_valid_q, ls_err_q;
   logic [31:0] if_rsp_data_q, ls_rsp_data_q;

   logic        gnt_if, gnt_ls, if_bad, ls_bad, ls_subword_st, in_rmw;
   size_e       ls_size_e, al_size;
   logic [31:0] al_word, al_load, al_merge;
   logic [1:0]  al_lo;
   logic [15:0] al_wdata;

   assign ls_size_e     = size_e'(ls_size);
   assign in_rmw        = (state_q == ST_RMW);
   assign if_bad        = addr_err(if_addr, SZ_WORD, MEM_WORDS);
   assign ls_bad        = addr_err(ls_addr, ls_size_e, MEM_WORDS);
   assign ls_subword_st = ls_we && !ls_bad && (ls_size_e != SZ_WORD);

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt_if = 1'b0;
      gnt_ls = 1'b0;
      if (!in_rmw && !reset) begin
         if (if_req_valid && (!ls_req_valid || last_grant_q == GNT_LS)) gnt_if = 1'b1;
         else if (ls_req_valid)                                         gnt_ls = 1'b1;
      end
   end

   assign if_req_ready = gnt_if;
   assign ls_req_ready = gnt_ls;

   assign al_word  = in_rmw ? merge_q          : ram_rd_data;
   assign al_lo    = in_rmw ? rmw_addr_q[1:0]  : ls_addr[1:0];
   assign al_size  = in_rmw ? rmw_size_q       : ls_size_e;
   assign al_wdata = in_rmw ? rmw_wdata_q      : ls_wdata[15:0];

   mem_lane_align u_align (
      .word_i     (al_word),
      .addr_lo_i  (al_lo),
      .size_i     (al_size),
      .unsigned_i (ls_unsigned),
      .wdata_i    (al_wdata),
      .load_o     (al_load),
      .merge_o    (al_merge)
   );

   // Erroneous accesses never reach the RAM; reset abandons an RMW write.
   always_comb begin
      ram_addr    = '0;
      ram_wr_sig  = 1'b0;
      ram_wr_data = '0;
      if (in_rmw) begin
         ram_addr    = {rmw_addr_q[31:2], 2'b00};
         ram_wr_sig  = !reset;
         ram_wr_data = al_merge;
      end else if (gnt_if && !if_bad) begin
         ram_addr = {if_addr[31:2], 2'b00};
      end else if (gnt_ls && !ls_bad) begin
         ram_addr = {ls_addr[31:2], 2'b00};
         if (ls_we && ls_size_e == SZ_WORD) begin
            ram_wr_sig  = 1'b1;
            ram_wr_data = ls_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= GNT_LS;
         if_rsp_valid_q <= 1'b0;
         if_err_q       <= 1'b0;
         if_rsp_data_q  <= '0;
         ls_rsp_valid_q <= 1'b0;
         ls_err_q       <= 1'b0;
         ls_rsp_data_q  <= '0;
      end else begin
         if_rsp_valid_q <= gnt_if;
         if_err_q       <= gnt_if && if_bad;
         if_rsp_data_q  <= (gnt_if && !if_bad) ? ram_rd_data : '0;
         ls_rsp_valid_q <= 1'b0;
         ls_err_q       <= 1'b0;
         ls_rsp_data_q  <= '0;
         if (gnt_if) last_grant_q <= GNT_IF;
         if (gnt_ls) last_grant_q <= GNT_LS;
         case (state_q)
            ST_IDLE: begin
               if (gnt_ls) begin
                  if (ls_subword_st) begin
                     state_q     <= ST_RMW;
                     merge_q     <= ram_rd_data;
                     rmw_addr_q  <= ls_addr;
                     rmw_size_q  <= ls_size_e;
                     rmw_wdata_q <= ls_wdata[15:0];
                  end else begin
                     ls_rsp_valid_q <= 1'b1;
                     ls_err_q       <= ls_bad;
                     ls_rsp_data_q  <= (!ls_we && !ls_bad) ? al_load : '0;
                  end
               end
            end
            ST_RMW: begin
               ls_rsp_valid_q <= 1'b1;
               state_q        <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign if_rsp_valid = if_rsp_valid_q;
   assign if_rsp_data  = if_rsp_data_q;
   assign if_err       = if_err_q;
   assign ls_rsp_valid = ls_rsp_valid_q;
   assign ls_rsp_data  = ls_rsp_data_q;
   assign ls_err       = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// RMW/reset sequences and a randomized run against a word-array model.
module tb_mem_arbiter;

   localparam int unsigned WORDS = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
   logic [31:0] if_addr, if_rsp_data;
   logic        ls_req_valid, ls_req_ready, ls_we, ls_unsigned, ls_rsp_valid, ls_err;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
   logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
   logic        ram_wr_sig;

   mem_arbiter #(.MEM_WORDS(WORDS)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_err(if_err),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_err(ls_err),
      .ram_addr(ram_addr), .ram_wr_sig(ram_wr_sig), .ram_wr_data(ram_wr_data),
      .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   logic [31:0] ram     [WORDS];
   logic [31:0] ref_mem [WORDS];

   assign ram_rd_data = ram[ram_addr[11:2]];
   always @(posedge clk) if (ram_wr_sig) ram[ram_addr[11:2]] <= ram_wr_data;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic is_err(input logic [31:0] a, input logic [1:0] sz);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
             || (a / 4 >= WORDS);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (32'(lo) * 8)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (32'(lo[1]) * 16)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] lo, input logic [1:0] sz);
      logic [31:0] mask;
      int unsigned sh;
      if (sz == 2'd2) return d;
      sh   = (sz == 2'd0) ? 32'(lo) * 8 : 32'(lo[1]) * 16;
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] data;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   // Issue one LS request alone, wait (bounded) for accept and response.
   task automatic ls_op(input vec_t v, input string tag);
      int n;
      int lat;
      ls_req_valid = 1'b1; ls_we = v.we; ls_size = v.size; ls_unsigned = v.uns;
      ls_addr = v.addr; ls_wdata = v.wdata; if_req_valid = 1'b0;
      #1;
      n = 0;
      while (!ls_req_ready && n < 8) begin @(posedge clk); #2; n++; end
      chk({tag, "_acc"}, 32'(ls_req_ready), 32'd1);
      @(posedge clk); #1;
      ls_req_valid = 1'b0;
      lat = 1;
      while (!ls_rsp_valid && lat < 4) begin @(posedge clk); #1; lat++; end
      chk({tag, "_lat"}, 32'(lat), (v.we && v.size < 2'd2 && !v.err) ? 32'd2 : 32'd1);
      chk({tag, "_err"}, 32'(ls_err), 32'(v.err));
      chk({tag, "_data"}, ls_rsp_data, v.data);
      if (v.we && !v.err)
         ref_mem[v.addr[11:2]] = merge(ref_mem[v.addr[11:2]], v.wdata, v.addr[1:0], v.size);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pif_due, pls_due, busy;
      logic        pif_err, pls_err, last_ls, gi, gl, e;
      logic [31:0] pif_data, pls_data;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000, 32'hCAFEF00D, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0013, 32'h0,        1'b0, 32'hFFFFFFDE};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0013, 32'h0,        1'b0, 32'h000000DE};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0011, 32'hFFFFFF55, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0010, 32'h0,        1'b0, 32'hDEAD55EF};
      vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0013, 32'h0,        1'b1, 32'h0};
      vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0};
      vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0010, 32'h0,        1'b1, 32'h0};
      vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0012, 32'h0,        1'b1, 32'h0};
      vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h0012, 32'h0,        1'b0, 32'hFFFFDEAD};
      vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h0010, 32'h0,        1'b0, 32'h000055EF};
      vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h0012, 32'hABCD1234, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0010, 32'h0,        1'b0, 32'h123455EF};
      vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h0011, 32'h00007777, 1'b1, 32'h0};
      vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0010, 32'h0,        1'b0, 32'h123455EF};
      vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h0010, 32'h0,        1'b0, 32'hFFFFFFEF};
      vecs[18] = '{1'b0, 2'd2, 1'b0, 32'h0000, 32'h0,        1'b0, 32'hCAFEF00D};

      for (int i = 0; i < int'(WORDS); i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end

      // Reset with both requesters asserting.
      reset = 1'b1; if_req_valid = 1'b1; ls_req_valid = 1'b1; if_addr = '0;
      ls_addr = 32'h40; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_if_rdy", 32'(if_req_ready), 32'd0);
         chk("rst_ls_rdy", 32'(ls_req_ready), 32'd0);
         chk("rst_if_v", 32'(if_rsp_valid), 32'd0);
         chk("rst_ls_v", 32'(ls_rsp_valid), 32'd0);
         chk("rst_wr", 32'(ram_wr_sig), 32'd0);
         chk("rst_data", if_rsp_data | ls_rsp_data, 32'd0);
      end
      reset = 1'b0;

      // Continuous contention: grants alternate starting with IF.
      for (int i = 0; i < 4; i++) begin
         if_addr = 32'(4 * i); ls_addr = 32'(32'h40 + 4 * i);
         #1;
         chk("alt_if_rdy", 32'(if_req_ready), 32'(i % 2 == 0));
         chk("alt_ls_rdy", 32'(ls_req_ready), 32'(i % 2 == 1));
         @(posedge clk); #1;
         chk("alt_if_v", 32'(if_rsp_valid), 32'(i % 2 == 0));
         chk("alt_ls_v", 32'(ls_rsp_valid), 32'(i % 2 == 1));
         if (i % 2 == 0) chk("alt_if_d", if_rsp_data, ref_mem[i]);
         else            chk("alt_ls_d", ls_rsp_data, ref_mem[16 + i]);
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;

      for (int i = 0; i < NV; i++) ls_op(vecs[i], $sformatf("v%0d", i));

      // Byte store with both sides waiting behind its RMW cycle.
      ls_op('{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0}, "st20");
      ls_req_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h22; ls_wdata = 32'h77;
      #1;
      chk("rmw_acc", 32'(ls_req_ready), 32'd1);
      @(posedge clk); #1;
      ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h20; if_req_valid = 1'b1; if_addr = 32'h0;
      #1;
      chk("rmw_ls_rdy", 32'(ls_req_ready), 32'd0);
      chk("rmw_if_rdy", 32'(if_req_ready), 32'd0);
      chk("rmw_wr", 32'(ram_wr_sig), 32'd1);
      chk("rmw_wdata", ram_wr_data, 32'h11773344);
      chk("rmw_addr", ram_addr, 32'h20);
      chk("rmw_no_rsp", 32'(ls_rsp_valid), 32'd0);
      @(posedge clk); #1;
      ref_mem[8] = 32'h11773344;
      chk("rmw_ack", 32'(ls_rsp_valid), 32'd1);
      chk("rmw_ack_err", 32'(ls_err), 32'd0);
      #1;
      chk("post_rmw_if", 32'(if_req_ready), 32'd1);
      chk("post_rmw_ls", 32'(ls_req_ready), 32'd0);
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      chk("post_rmw_if_d", if_rsp_data, ref_mem[0]);

      // Reset landing on the RMW cycle abandons the write.
      ls_req_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h23; ls_wdata = 32'h99;
      #1;
      chk("rrst_acc", 32'(ls_req_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1; ls_req_valid = 1'b0;
      #1;
      chk("rrst_wr", 32'(ram_wr_sig), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rrst_no_ack", 32'(ls_rsp_valid), 32'd0);
      ls_op('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11773344}, "rrst_rd");

      // Fetch errors: out of range and misaligned.
      if_req_valid = 1'b1; if_addr = 32'h1000;
      #1;
      chk("iferr_rdy", 32'(if_req_ready), 32'd1);
      @(posedge clk); #1;
      chk("iferr_v", 32'(if_rsp_valid), 32'd1);
      chk("iferr_e", 32'(if_err), 32'd1);
      chk("iferr_d", if_rsp_data, 32'd0);
      if_addr = 32'h22;
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      chk("ifmis_e", 32'(if_err), 32'd1);
      chk("ifmis_d", if_rsp_data, 32'd0);

      // Randomized traffic against the word-array model.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last_ls = 1'b1; pif_due = -1; pls_due = -1; busy = -1;
      pif_err = 1'b0; pls_err = 1'b0; pif_data = '0; pls_data = '0;
      for (int k = 0; k < 600; k++) begin
         chk("rnd_if_v", 32'(if_rsp_valid), 32'(pif_due == k));
         if (pif_due == k) begin
            chk("rnd_if_e", 32'(if_err), 32'(pif_err));
            chk("rnd_if_d", if_rsp_data, pif_data);
         end
         chk("rnd_ls_v", 32'(ls_rsp_valid), 32'(pls_due == k));
         if (pls_due == k) begin
            chk("rnd_ls_e", 32'(ls_err), 32'(pls_err));
            chk("rnd_ls_d", ls_rsp_data, pls_data);
         end

         if_req_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 15))
            0:       if_addr = 32'h1000 + 4 * $urandom_range(0, 255);
            1:       if_addr = $urandom_range(0, 255);
            default: if_addr = 4 * $urandom_range(0, 63);
         endcase
         ls_req_valid = ($urandom_range(0, 3) != 0);
         ls_size      = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         ls_addr      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FF00 | $urandom_range(0, 255)
                                                     : $urandom_range(0, 255);
         ls_we        = $urandom_range(0, 1) == 1;
         ls_unsigned  = $urandom_range(0, 1) == 1;
         ls_wdata     = $urandom;
         #1;
         gi = 1'b0; gl = 1'b0;
         if (k != busy) begin
            if (if_req_valid && (!ls_req_valid || last_ls)) gi = 1'b1;
            else if (ls_req_valid)                          gl = 1'b1;
         end
         chk("rnd_if_rdy", 32'(if_req_ready), 32'(gi));
         chk("rnd_ls_rdy", 32'(ls_req_ready), 32'(gl));
         if (gi) begin
            last_ls  = 1'b0;
            pif_due  = k + 1;
            pif_err  = is_err(if_addr, 2'd2);
            pif_data = pif_err ? 32'd0 : ref_mem[if_addr[11:2]];
         end
         if (gl) begin
            last_ls  = 1'b1;
            e        = is_err(ls_addr, ls_size);
            pls_err  = e;
            pls_data = (!ls_we && !e) ? exp_load(ref_mem[ls_addr[11:2]], ls_addr[1:0],
                                                 ls_size, ls_unsigned) : 32'd0;
            if (ls_we && !e && ls_size != 2'd2) begin
               pls_due = k + 2;
               busy    = k + 1;
            end else begin
               pls_due = k + 1;
            end
            if (ls_we && !e)
               ref_mem[ls_addr[11:2]] = merge(ref_mem[ls_addr[11:2]], ls_wdata,
                                              ls_addr[1:0], ls_size);
         end
         @(posedge clk); #1;
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < int'(WORDS); i++) chk($sformatf("mem%0d", i), ram[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
